// File: rtl/rr_sel_pkg.sv
// Shared constants, FSM state type and small helpers for the round-robin select generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rr_sel_pkg;

    // Number of request channels; matches the width of the downstream word mux.
    localparam int N_CH  = 16;
    // Select width, log2(N_CH).
    localparam int SEL_W = 4;

    // IDLE: no grant outstanding. GRANT: sel/out_valid presented, waiting for accept.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

    // Next start point after a channel was served. SEL_W-bit arithmetic wraps 15 -> 0.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return s + SEL_W'(1);
    endfunction

    // One-hot decode of a select value.
    function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] s);
        return N_CH'(1) << s;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Rotating-priority picker: first set bit of req scanning ptr, ptr+1, ... modulo N_CH.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   req  - per-channel request vector
//   ptr  - channel with highest priority for this pick
//   win  - index of the winning channel (don't-care when any=0)
//   any  - at least one request is set
module rr_pick16
    import rr_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    logic [2*N_CH-1:0] req_dbl;
    logic [2*N_CH-1:0] req_shift;
    logic [N_CH-1:0]   req_rot;
    logic [SEL_W-1:0]  off;

    always_comb begin
        // Rotate right by ptr so that channel ptr lands on bit 0; the doubled
        // vector makes the wrap-around fall out of a plain shift.
        req_dbl   = {req, req};
        req_shift = req_dbl >> ptr;
        req_rot   = req_shift[N_CH-1:0];

        // Priority encode the rotated vector, lowest bit wins. Scanning from the
        // top and overwriting leaves the lowest set bit in off.
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SEL_W'(i);
            end
        end

        any = |req;
        // Undo the rotation; SEL_W-bit addition wraps modulo N_CH.
        win = ptr + off;
    end

endmodule

// File: rtl/rr_sel_16.sv
// Round-robin select generator for a 16:1 word mux; the channel served last gets lowest priority next.
// Latency: req sampled at edge N gives out_valid/sel in cycle N+1; one grant per cycle back-to-back.
// Backpressure: a presented grant (sel/out_valid) is held unchanged until out_ready; never withdrawn.
//
// Optional feature: define RR_ONEHOT_GNT_EN to add the registered one-hot gnt output.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset, overrides every other input
//   req        - level-sensitive per-channel requests, sampled every cycle
//   out_ready  - consumer accepts the current select (don't-care while out_valid=0)
//   sel        - registered mux select
//   out_valid  - sel is a valid grant
//   gnt        - (RR_ONEHOT_GNT_EN only) one-hot of sel while out_valid, else 0
module rr_sel_16
    import rr_sel_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid
`ifdef RR_ONEHOT_GNT_EN
    ,
    output logic [N_CH-1:0]  gnt
`endif
);

    rr_state_t        state_q,     state_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic [SEL_W-1:0] sel_q,       sel_d;
    logic             out_valid_q, out_valid_d;
`ifdef RR_ONEHOT_GNT_EN
    logic [N_CH-1:0]  gnt_q,       gnt_d;
`endif

    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_win;
    logic             pick_any;

    // In GRANT the only pick that matters is the one on accept, which must start
    // just past the channel being served -- the same value ptr takes this edge.
    // Using sel_q+1 directly avoids waiting a cycle for ptr_q to update.
    assign pick_ptr = (state_q == GRANT) ? sel_inc(sel_q) : ptr_q;

    rr_pick16 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .win (pick_win),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d       = pick_win;
                    out_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Without an accept everything holds and req is ignored, even if
                // the granted channel drops its request.
                if (out_ready) begin
                    ptr_d = sel_inc(sel_q);
                    if (pick_any) begin
                        sel_d = pick_win;
                    end else begin
                        // sel keeps its last value; it is unqualified while out_valid=0.
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

`ifdef RR_ONEHOT_GNT_EN
    // Derived from the next-state values so gnt is a register aligned with sel.
    always_comb begin
        gnt_d = out_valid_d ? sel_onehot(sel_d) : '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef RR_ONEHOT_GNT_EN
            gnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
`ifdef RR_ONEHOT_GNT_EN
            gnt_q       <= gnt_d;
`endif
        end
    end

    assign sel       = sel_q;
    assign out_valid = out_valid_q;
`ifdef RR_ONEHOT_GNT_EN
    assign gnt       = gnt_q;
`endif

endmodule

// File: tb/tb_rr_sel_16.sv
// Self-checking bench for rr_sel_16: reference model predicts each cycle's outputs into a queue,
// a monitor pops and compares one cycle later.
// Directed scenarios first, then randomized requests/ready/reset.
module tb_rr_sel_16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        out_ready;
    logic [3:0]  sel;
    logic        out_valid;
`ifdef RR_ONEHOT_GNT_EN
    logic [15:0] gnt;
`endif

    rr_sel_16 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid)
`ifdef RR_ONEHOT_GNT_EN
        ,
        .gnt       (gnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        vld;
        logic [3:0]  sel;
        logic        chk_sel;
        logic [15:0] gnt;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: a pending grant (valid + channel) and the next
    // highest-priority channel, updated from the rules with integer arithmetic.
    int   m_ptr   = 0;
    int   m_sel   = 0;
    bit   m_vld   = 0;
    bit   m_fresh = 1;   // no grant since reset, so sel must still read 0

    function automatic int pick(input logic [15:0] r, input int start);
        for (int k = 0; k < 16; k++) begin
            if (r[(start + k) % 16]) return (start + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] r, input logic rd, input logic rs);
        if (rs) begin
            m_vld = 0; m_sel = 0; m_ptr = 0; m_fresh = 1;
        end else if (!m_vld) begin
            if (r != 16'h0) begin
                m_sel = pick(r, m_ptr); m_vld = 1; m_fresh = 0;
            end
        end else if (rd) begin
            m_ptr = (m_sel + 1) % 16;
            if (r != 16'h0) m_sel = pick(r, m_ptr);
            else            m_vld = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, and queue what the DUT
    // should show after the coming rising edge.
    task automatic step(input logic [15:0] r, input logic rd, input logic rs, input string tag);
        exp_t e;
        @(negedge clk);
        req = r; out_ready = rd; rst = rs;
        model_step(r, rd, rs);
        e.vld     = m_vld;
        e.sel     = 4'(m_sel);
        e.chk_sel = m_vld || m_fresh;
        e.gnt     = m_vld ? (16'h1 << m_sel) : 16'h0;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every cycle's outputs against the queued prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (out_valid !== e.vld) begin
                n_fail++;
                $display("FAIL %s out_valid: got %b expected %b", e.tag, out_valid, e.vld);
            end
            if (e.chk_sel) begin
                n_checks++;
                if (sel !== e.sel) begin
                    n_fail++;
                    $display("FAIL %s sel: got %0d expected %0d", e.tag, sel, e.sel);
                end
            end
`ifdef RR_ONEHOT_GNT_EN
            n_checks++;
            if (gnt !== e.gnt) begin
                n_fail++;
                $display("FAIL %s gnt: got %h expected %h", e.tag, gnt, e.gnt);
            end
`endif
        end
    end

    initial begin
        logic [15:0] r;
        logic        rd;
        logic        rs;
        req = '0; out_ready = 1'b0; rst = 1'b1;

        step(16'h0000, 1'b0, 1'b1, "reset");
        step(16'h0000, 1'b0, 1'b1, "reset");
        for (int i = 0; i < 5; i++) step(16'h0000, 1'b1, 1'b0, "idle_noreq");

        // Single requester served every cycle.
        for (int i = 0; i < 6; i++) step(16'h0001, 1'b1, 1'b0, "single_ch0");
        step(16'h0000, 1'b1, 1'b0, "single_drain");
        step(16'h0000, 1'b1, 1'b0, "single_drain");

        // Four requesters rotate 0,5,10,15.
        for (int i = 0; i < 10; i++) step(16'h8421, 1'b1, 1'b0, "rotate_8421");
        step(16'h0000, 1'b1, 1'b0, "rotate_drain");
        step(16'h0000, 1'b1, 1'b0, "rotate_drain");

        // Held grant survives the request dropping; accept then returns to idle.
        step(16'h0010, 1'b0, 1'b0, "hold_ch4");
        step(16'h0000, 1'b0, 1'b0, "hold_ch4");
        step(16'h0000, 1'b0, 1'b0, "hold_ch4");
        step(16'h0000, 1'b0, 1'b0, "hold_ch4");
        step(16'h0000, 1'b1, 1'b0, "hold_accept");
        step(16'h0000, 1'b1, 1'b0, "hold_idle");

        // Reset while granting channel 7 drops the grant; next grant starts at 0.
        step(16'h0080, 1'b0, 1'b0, "rst_mid_grant");
        step(16'hFFFF, 1'b0, 1'b0, "rst_mid_grant");
        step(16'hFFFF, 1'b0, 1'b1, "rst_mid_grant_pulse");
        step(16'hFFFF, 1'b1, 1'b0, "post_reset_first");
        step(16'hFFFF, 1'b1, 1'b0, "post_reset_next");
        step(16'h0000, 1'b1, 1'b0, "post_reset_drain");
        step(16'h0000, 1'b1, 1'b0, "post_reset_drain");

        // Channel 9 grant and its clear after accept.
        step(16'h0200, 1'b0, 1'b0, "ch9_grant");
        step(16'h0000, 1'b1, 1'b0, "ch9_accept");
        step(16'h0000, 1'b1, 1'b0, "ch9_idle");

        // Randomized traffic.
        r = 16'h0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 16'h0;
                1:       r = 16'h1 << $urandom_range(0, 15);
                2:       r = 16'($urandom);
                default: r = r;
            endcase
            rd = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 99) == 0);
            step(r, rd, rs, "random");
        end

        @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
